// File: rtl/coz_pkg.sv
// Shared decode vocabulary for the coz stage: operation codes, RV32I opcodes, the fetch NOP word.
package coz_paket;

    localparam logic [31:0] NOP_KELIME = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // MUL..REMU must stay contiguous and in funct3 order; the decoder indexes them by funct3.
    typedef enum logic [5:0] {
        ISLEM_YOK,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK, MRET,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } islem_e;

    typedef enum logic {
        NORMAL,
        BALON
    } durum_e;

endpackage

// File: rtl/coz_if.sv
// Decode-stage bundle: fetch-side inputs plus the registered decode outputs and the fetch stall request.
interface coz_if;
    logic [31:0] ps_i;
    logic [31:0] buyruk_i;
    logic        durdur_i;
    logic        bosalt_i;
    logic [31:0] ps_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [31:0] imm_o;
    logic [5:0]  islem_o;
    logic        gecerli_o;
    logic        yaz_o;
    logic        bellek_oku_o;
    logic        bellek_yaz_o;
    logic        yasadisi_buyruk_o;
    logic        getir_durdur_o;

    modport slave (
        input  ps_i, buyruk_i, durdur_i, bosalt_i,
        output ps_o, rd_o, rs1_o, rs2_o, imm_o, islem_o, gecerli_o, yaz_o,
               bellek_oku_o, bellek_yaz_o, yasadisi_buyruk_o, getir_durdur_o
    );

    modport master (
        output ps_i, buyruk_i, durdur_i, bosalt_i,
        input  ps_o, rd_o, rs1_o, rs2_o, imm_o, islem_o, gecerli_o, yaz_o,
               bellek_oku_o, bellek_yaz_o, yasadisi_buyruk_o, getir_durdur_o
    );
endinterface

// File: rtl/coz_anlik_uretici.sv
// anlik_uretici: combinational RV32I immediate generator, sign-extended from bit 31; R-type and unknown give 0.
module anlik_uretici
    import coz_paket::*;
(
    input  logic [31:0] i_buyruk,
    output logic [31:0] o_imm
);
    always_comb begin
        o_imm = '0;
        case (i_buyruk[6:0])
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:
                o_imm = {{20{i_buyruk[31]}}, i_buyruk[31:20]};
            OP_STORE:
                o_imm = {{20{i_buyruk[31]}}, i_buyruk[31:25], i_buyruk[11:7]};
            OP_BRANCH:
                o_imm = {{19{i_buyruk[31]}}, i_buyruk[31], i_buyruk[7],
                         i_buyruk[30:25], i_buyruk[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                o_imm = {i_buyruk[31:12], 12'h000};
            OP_JAL:
                o_imm = {{11{i_buyruk[31]}}, i_buyruk[31], i_buyruk[19:12],
                         i_buyruk[20], i_buyruk[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end
endmodule

// File: rtl/coz.sv
// coz: RV32I decode stage, 1-cycle registered; durdur_i holds everything, load-use inserts one bubble via getir_durdur_o.
// Build option M_UZANTISI_EN adds the RV32M operations; without it they decode as illegal.
module coz
    import coz_paket::*;
#(
    parameter logic [31:0] NOP_BUYRUK = NOP_KELIME
) (
    input  logic clk_i,
    input  logic rst_i,
    coz_if.slave yol
);
    logic [6:0]  w_opkod;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    islem_e      w_islem;
    logic        w_gecerli, w_yaz, w_oku, w_byaz, w_yasadisi, w_tehlike;
    durum_e      r_durum, w_durum_sonraki;

    logic [31:0] r_ps, r_imm;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    islem_e      r_islem;
    logic        r_gecerli, r_yaz, r_oku, r_byaz, r_yasadisi;

    assign w_opkod = yol.buyruk_i[6:0];
    assign w_f3    = yol.buyruk_i[14:12];
    assign w_f7    = yol.buyruk_i[31:25];

    anlik_uretici u_anlik (.i_buyruk(yol.buyruk_i), .o_imm(w_imm));

    always_comb begin
        w_islem = ISLEM_YOK;
        w_rd    = yol.buyruk_i[11:7];
        w_rs1   = yol.buyruk_i[19:15];
        w_rs2   = '0;
        w_yaz   = 1'b0;
        w_oku   = 1'b0;
        w_byaz  = 1'b0;
        case (w_opkod)
            OP_LUI:   begin w_islem = LUI;   w_rs1 = '0; w_yaz = 1'b1; end
            OP_AUIPC: begin w_islem = AUIPC; w_rs1 = '0; w_yaz = 1'b1; end
            OP_JAL:   begin w_islem = JAL;   w_rs1 = '0; w_yaz = 1'b1; end
            OP_JALR:  begin w_yaz = 1'b1; if (w_f3 == 3'b000) w_islem = JALR; end
            OP_BRANCH: begin
                w_rd  = '0;
                w_rs2 = yol.buyruk_i[24:20];
                case (w_f3)
                    3'b000: w_islem = BEQ;
                    3'b001: w_islem = BNE;
                    3'b100: w_islem = BLT;
                    3'b101: w_islem = BGE;
                    3'b110: w_islem = BLTU;
                    3'b111: w_islem = BGEU;
                    default: ;
                endcase
            end
            OP_LOAD: begin
                w_oku = 1'b1;
                w_yaz = 1'b1;
                case (w_f3)
                    3'b000: w_islem = LB;
                    3'b001: w_islem = LH;
                    3'b010: w_islem = LW;
                    3'b100: w_islem = LBU;
                    3'b101: w_islem = LHU;
                    default: ;
                endcase
            end
            OP_STORE: begin
                w_rd   = '0;
                w_rs2  = yol.buyruk_i[24:20];
                w_byaz = 1'b1;
                case (w_f3)
                    3'b000: w_islem = SB;
                    3'b001: w_islem = SH;
                    3'b010: w_islem = SW;
                    default: ;
                endcase
            end
            OP_IMM: begin
                w_yaz = 1'b1;
                case (w_f3)
                    3'b000: w_islem = ADDI;
                    3'b010: w_islem = SLTI;
                    3'b011: w_islem = SLTIU;
                    3'b100: w_islem = XORI;
                    3'b110: w_islem = ORI;
                    3'b111: w_islem = ANDI;
                    3'b001: if (w_f7 == 7'b0000000) w_islem = SLLI;
                    3'b101: begin
                        if (w_f7 == 7'b0000000)      w_islem = SRLI;
                        else if (w_f7 == 7'b0100000) w_islem = SRAI;
                    end
                    default: ;
                endcase
            end
            OP_REG: begin
                w_yaz = 1'b1;
                w_rs2 = yol.buyruk_i[24:20];
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000: w_islem = ADD;
                        3'b001: w_islem = SLL;
                        3'b010: w_islem = SLT;
                        3'b011: w_islem = SLTU;
                        3'b100: w_islem = XOR;
                        3'b101: w_islem = SRL;
                        3'b110: w_islem = OR;
                        3'b111: w_islem = AND;
                        default: ;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'b000)      w_islem = SUB;
                    else if (w_f3 == 3'b101) w_islem = SRA;
                end
`ifdef M_UZANTISI_EN
                else if (w_f7 == 7'b0000001) begin
                    w_islem = islem_e'(6'(MUL) + {3'b000, w_f3});
                end
`endif
            end
            OP_FENCE: begin w_rd = '0; if (w_f3 == 3'b000) w_islem = FENCE; end
            OP_SYSTEM: begin
                w_rd = '0;
                case (yol.buyruk_i)
                    32'h0000_0073: w_islem = ECALL;
                    32'h0010_0073: w_islem = EBREAK;
                    32'h3020_0073: w_islem = MRET;
                    default: ;
                endcase
            end
            default: ;
        endcase

        w_gecerli  = 1'b1;
        w_yasadisi = (w_islem == ISLEM_YOK);
        if (w_yasadisi) {w_yaz, w_oku, w_byaz} = 3'b000;
        if (w_rd == 5'd0) w_yaz = 1'b0;
        if (yol.buyruk_i == NOP_BUYRUK) begin
            w_gecerli  = 1'b0;
            w_yasadisi = 1'b0;
            w_islem    = ISLEM_YOK;
            {w_yaz, w_oku, w_byaz} = 3'b000;
        end
    end

    // Unused source fields decode to 0, so comparing against a non-zero rd never matches them.
    assign w_tehlike = (r_durum == NORMAL) && r_gecerli && r_oku && (r_rd != 5'd0)
                     && ((w_rs1 == r_rd) || (w_rs2 == r_rd));
    assign yol.getir_durdur_o = w_tehlike && !yol.bosalt_i && !rst_i;

    always_comb begin
        w_durum_sonraki = r_durum;
        if (yol.bosalt_i)       w_durum_sonraki = NORMAL;
        else if (!yol.durdur_i) w_durum_sonraki = w_tehlike ? BALON : NORMAL;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_durum <= NORMAL;
        else       r_durum <= w_durum_sonraki;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ps <= '0; r_imm <= '0; r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0;
            r_islem <= ISLEM_YOK;
            r_gecerli <= 1'b0; r_yaz <= 1'b0; r_oku <= 1'b0; r_byaz <= 1'b0; r_yasadisi <= 1'b0;
        end else if (yol.bosalt_i) begin
            r_gecerli <= 1'b0; r_yaz <= 1'b0; r_oku <= 1'b0; r_byaz <= 1'b0; r_yasadisi <= 1'b0;
        end else if (!yol.durdur_i) begin
            r_ps       <= yol.ps_i;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_islem    <= w_tehlike ? ISLEM_YOK : w_islem;
            r_gecerli  <= w_gecerli  && !w_tehlike;
            r_yaz      <= w_yaz      && !w_tehlike;
            r_oku      <= w_oku      && !w_tehlike;
            r_byaz     <= w_byaz     && !w_tehlike;
            r_yasadisi <= w_yasadisi && !w_tehlike;
        end
    end

    assign yol.ps_o              = r_ps;
    assign yol.imm_o             = r_imm;
    assign yol.rd_o              = r_rd;
    assign yol.rs1_o             = r_rs1;
    assign yol.rs2_o             = r_rs2;
    assign yol.islem_o           = r_islem;
    assign yol.gecerli_o         = r_gecerli;
    assign yol.yaz_o             = r_yaz;
    assign yol.bellek_oku_o      = r_oku;
    assign yol.bellek_yaz_o      = r_byaz;
    assign yol.yasadisi_buyruk_o = r_yasadisi;
endmodule

// File: doc/coz.md
COZ -- requirements
Module: coz

Interface
REQ-001 SHALL have parameter NOP_BUYRUK, default 32'h0000_0013, the canonical NOP word that the upstream fetch stage emits when it has no instruction ready.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ps_i, input, 32 bits: program counter of buyruk_i, from the fetch stage's ps_o.
REQ-005 SHALL have port buyruk_i, input, 32 bits: instruction word, from the fetch stage's buyruk_o.
REQ-006 SHALL have port durdur_i, input, 1 bit: downstream stall; hold every output register.
REQ-007 SHALL have port bosalt_i, input, 1 bit: flush (dallanma_hata | jal_gecerli | mret_gecerli).
REQ-008 SHALL have output port ps_o, 32 bits: the registered PC.
REQ-009 SHALL have output ports rd_o, rs1_o and rs2_o, 5 bits each: the registered register indices.
REQ-010 SHALL have output port imm_o, 32 bits: the sign-extended immediate.
REQ-011 SHALL have output port islem_o, 6 bits: the operation code from the package enum.
REQ-012 SHALL have output port gecerli_o, 1 bit: the output bundle holds a real instruction.
REQ-013 SHALL have output ports yaz_o (register-file write), bellek_oku_o (load) and bellek_yaz_o (store), 1 bit each.
REQ-014 SHALL have output port yasadisi_buyruk_o, 1 bit: illegal instruction.
REQ-015 SHALL have output port getir_durdur_o, 1 bit: combinational stall request to fetch.

Function
REQ-016 SHALL register the decode of buyruk_i/ps_i with 1-cycle latency when durdur_i=0, bosalt_i=0 and no hazard.
REQ-017 SHALL, on durdur_i=1, hold all registered outputs and state; getir_durdur_o is still computed.
REQ-018 SHALL, on bosalt_i=1, on the next edge clear gecerli_o, yaz_o, bellek_oku_o, bellek_yaz_o and yasadisi_buyruk_o and force state NORMAL; bosalt_i overrides durdur_i and any hazard.
REQ-019 SHALL, when buyruk_i==NOP_BUYRUK, register gecerli_o=0 with all control outputs 0.
REQ-020 SHALL generate I/S/B/U/J immediates per RV32I, sign-extended from bit 31; R-type imm_o=0.
REQ-021 SHALL drive rs2_o from bits 24:20 only for R, S and B types, and 0 otherwise; rs1_o SHALL be 0 for U/J.
REQ-022 SHALL, for an unknown opcode/funct combination, register gecerli_o=1, yasadisi_buyruk_o=1 and yaz_o/bellek_oku_o/bellek_yaz_o=0.
REQ-023 SHALL force yaz_o=0 when rd==0.
REQ-024 SHALL use states NORMAL and BALON.
REQ-025 SHALL detect a hazard in NORMAL when gecerli_o & bellek_oku_o & rd_o!=0 & rd_o matches a used rs1/rs2 of buyruk_i.
REQ-026 SHALL, on a hazard, assert getir_durdur_o=1 in the same cycle, register a bubble (gecerli_o=0, controls 0) and go to BALON.
REQ-027 SHALL, in BALON, hold getir_durdur_o=0, decode the held buyruk_i normally and return to NORMAL.
REQ-028 SHALL hold state unchanged in BALON when durdur_i=1.

Reset
REQ-029 SHALL, on rst_i=1 at a clock edge, zero every output register, set state NORMAL and drive getir_durdur_o=0; reset overrides bosalt_i and durdur_i.

Configuration
REQ-030 SHALL decode, with M_UZANTISI_EN defined, opcode 0110011 with funct7=0000001 as MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU (yaz_o=1).
REQ-031 SHALL, without M_UZANTISI_EN, treat that encoding as illegal per REQ-022.

Structure
REQ-032 SHALL place the islem enum (6-bit), the opcode localparams and the NOP word in shared package coz_paket.
REQ-033 SHALL instantiate one combinational sub-module, anlik_uretici (instruction -> imm_o).

Verification
REQ-034 SHALL cover reset: rst_i=1 then 0 -> all outputs 0 and getir_durdur_o=0.
REQ-035 SHALL cover ADDI: buyruk_i=0x00500093 -> next cycle gecerli_o=1, rd_o=1, imm_o=5, yaz_o=1.
REQ-036 SHALL cover a store: 0xFE112C23 -> next cycle imm_o=0xFFFFFFF8, rs1_o=2, rs2_o=1, bellek_yaz_o=1, yaz_o=0.
REQ-037 SHALL cover load-use: 0x0000A103 then 0x002101B3 -> getir_durdur_o=1 for exactly one cycle, one bubble, then ADD with rd_o=3.
REQ-038 SHALL cover flush: bosalt_i=1 together with durdur_i=1 -> gecerli_o=0 next cycle, state NORMAL.
REQ-039 SHALL cover MUL: 0x027302B3 -> islem_o=MUL with M_UZANTISI_EN; yasadisi_buyruk_o=1 without it.
